mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous data port (port B) of the 16-bit unified RAM between two requesters: the CPU load/store path (LB/SB states of the control FSM) and a peripheral/DMA master.
- Round-robin arbitration with a registered req/gnt handshake and fixed one-cycle RAM read latency.
- Sits between the control/datapath and the RAM's port-B pins (mem_wren maps to wren_b).

Parameters:
- WIDTH, 16, data word width.
- ADDR_W, 16, RAM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  WIDTH  CPU write data
- cpu_gnt  out  1  one-cycle grant; the request is consumed this cycle
- cpu_rvalid  out  1  one-cycle read-data valid
- cpu_rdata  out  WIDTH  read data, valid when cpu_rvalid
- per_req, per_we, per_addr, per_wdata, per_gnt, per_rvalid, per_rdata  same as cpu_* for the peripheral
- mem_en  out  1  RAM port-B enable
- mem_wren  out  1  RAM port-B write enable
- mem_addr  out  ADDR_W  RAM port-B address
- mem_wdata  out  WIDTH  RAM port-B write data
- mem_rdata  in  WIDTH  RAM port-B read data, valid one cycle after a read-enabled cycle

Behaviour:
- Reset (async, active-high): state=IDLE; all gnt/rvalid/mem_en/mem_wren=0; mem_addr/mem_wdata/rdata outputs=0; last_winner=PER, so the CPU wins the first tie.
- States: IDLE, CPU_ACC, PER_ACC, CPU_RD, PER_RD.
- Arbitration is sampled only in IDLE, CPU_RD and PER_RD.
  - One requester high: it wins.
  - Both high: the requester that is not last_winner wins.
  - last_winner updates on entry to an ACC state.
- X_ACC (one cycle): x_gnt=1; mem_en=1; mem_wren=x_we; mem_addr/mem_wdata driven from x_addr/x_wdata.
  - Next state: X_RD if x_we=0, else re-arbitrate as from IDLE.
  - x_req in the X_ACC cycle is ignored for arbitration; it is the request being consumed.
- X_RD (one cycle): x_rvalid=1; x_rdata=mem_rdata; then arbitrate.
  - x_req high in X_RD is a new request.
- Latency: req sampled at cycle N -> gnt at N+1 -> rvalid/rdata at N+2 (reads).
- Throughput: writes one per cycle; reads one per two cycles.
- Idle port: mem_en=0, mem_wren=0; mem_addr/mem_wdata hold their last value.
- rdata outputs register the RAM data in X_RD and hold it until the next rvalid for that requester.
- Requester dropping req before gnt: legal. The arbiter has no memory of it, and no gnt is issued if req is low at the arbitration point.
- Reset mid-read: the pending rvalid is suppressed, and a write in its ACC cycle may or may not land in RAM. Software must not rely on it.
- Never both gnts in one cycle; never rvalid on a write.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds three 16-bit saturating counters, reset to 0.
  - cpu_grants and per_grants increment on each gnt.
  - conflicts increments on each arbitration point with both reqs high.
  - Exposed as output ports perf_cpu_grants, perf_per_grants, perf_conflicts; input perf_clr (synchronous, clears all counters, has priority over increment).
- Undefined: counters and these ports are absent; arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=3'd0, CPU_ACC=3'd1, PER_ACC=3'd2, CPU_RD=3'd3, PER_RD=3'd4)
  - requester IDs (REQ_CPU=1'b0, REQ_PER=1'b1)
  - perf counter width constant (16)
- Sub-module rr_arb2: purely the 2-way round-robin pick (req[1:0], last_winner -> winner, valid). Instantiated once.

Test Plan:
- Single CPU read of addr 0x0010 (RAM holds 0xBEEF): cpu_req at N -> cpu_gnt at N+1 with mem_en=1, mem_wren=0, mem_addr=0x0010 -> cpu_rvalid=1, cpu_rdata=0xBEEF at N+2.
- Continuous collision: cpu_req=per_req=1 continuously, both writes -> gnts alternate CPU, PER, CPU, PER on consecutive cycles; mem_wdata follows the winner; no cycle has both gnts.
- Back-to-back reads, peripheral reads 0x0020 then 0x0021 with per_req held high -> gnt, rvalid, gnt, rvalid pattern with a 2-cycle period; data 0x1234, 0x5678 returned in order.
- Mid-read reset: assert reset in PER_RD -> per_rvalid=0 immediately (async); state=IDLE; after deassert, a cpu_req wins the tie, since last_winner=PER.
- Write then read same address: CPU writes 0xA5A5 to 0x0100, then reads 0x0100 -> cpu_rdata=0xA5A5, 3 cycles after the write gnt.
- With ARB_PERF_CNT_EN: 4 collisions plus 2 solo CPU accesses -> conflicts=4, cpu_grants=4, per_grants=2. Pulse perf_clr -> all 0 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared state encoding, requester IDs and counter width for the
//            RAM port-B arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_ACC = 3'd1,
        PER_ACC = 3'd2,
        CPU_RD  = 3'd3,
        PER_RD  = 3'd4
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_PER = 1'b1;

    localparam int PERF_W = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin pick; on a tie the requester that did not
//            win last time is chosen.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = REQ_CPU;
        if (req == 2'b11) begin
            winner = ~last_winner;
        end else if (req[REQ_PER]) begin
            winner = REQ_PER;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin sharing of RAM port B between CPU and peripheral
//            masters. ARB_PERF_CNT_EN adds grant/conflict counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [WIDTH-1:0]  cpu_rdata,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [WIDTH-1:0]  per_wdata,
    output logic              per_gnt,
    output logic              per_rvalid,
    output logic [WIDTH-1:0]  per_rdata,
    output logic              mem_en,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_cpu_grants,
    output logic [PERF_W-1:0] perf_per_grants,
    output logic [PERF_W-1:0] perf_conflicts
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic             last_winner;
    logic             acc_we;
    logic [1:0]       arb_req;
    logic             arb_point;
    logic             win;
    logic             win_valid;
    logic             enter_acc;
    logic [WIDTH-1:0] cpu_rdata_q;
    logic [WIDTH-1:0] per_rdata_q;

    // The request being consumed in its own ACC cycle must not re-win.
    assign arb_req = {per_req & (state != PER_ACC), cpu_req & (state != CPU_ACC)};

    rr_arb2 u_rr_arb2 (
        .req         (arb_req),
        .last_winner (last_winner),
        .winner      (win),
        .valid       (win_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arb_point = 1'b0;
        case (state)
            CPU_ACC: if (acc_we) arb_point = 1'b1; else state_nxt = CPU_RD;
            PER_ACC: if (acc_we) arb_point = 1'b1; else state_nxt = PER_RD;
            default: arb_point = 1'b1;
        endcase
        if (arb_point) begin
            if (win_valid) begin
                state_nxt = (win == REQ_PER) ? PER_ACC : CPU_ACC;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    assign enter_acc = arb_point & win_valid;

    // Address/data are captured on entry to ACC so the port holds them when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner <= REQ_PER;
            acc_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rdata_q <= '0;
            per_rdata_q <= '0;
        end else begin
            if (enter_acc) begin
                last_winner <= win;
                if (win == REQ_PER) begin
                    acc_we    <= per_we;
                    mem_addr  <= per_addr;
                    mem_wdata <= per_wdata;
                end else begin
                    acc_we    <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
            end
            if (state == CPU_RD) cpu_rdata_q <= mem_rdata;
            if (state == PER_RD) per_rdata_q <= mem_rdata;
        end
    end

    assign cpu_gnt    = (state == CPU_ACC);
    assign per_gnt    = (state == PER_ACC);
    assign mem_en     = cpu_gnt | per_gnt;
    assign mem_wren   = mem_en & acc_we;
    assign cpu_rvalid = (state == CPU_RD);
    assign per_rvalid = (state == PER_RD);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign per_rdata  = per_rvalid ? mem_rdata : per_rdata_q;

`ifdef ARB_PERF_CNT_EN
    localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cpu_grants <= '0;
            perf_per_grants <= '0;
            perf_conflicts  <= '0;
        end else if (perf_clr) begin
            perf_cpu_grants <= '0;
            perf_per_grants <= '0;
            perf_conflicts  <= '0;
        end else begin
            if (cpu_gnt && perf_cpu_grants != CNT_MAX) perf_cpu_grants <= perf_cpu_grants + 1'b1;
            if (per_gnt && perf_per_grants != CNT_MAX) perf_per_grants <= perf_per_grants + 1'b1;
            if (arb_point && arb_req == 2'b11 && perf_conflicts != CNT_MAX) begin
                perf_conflicts <= perf_conflicts + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with a 1-cycle-latency RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    typedef struct {
        bit          per;
        bit          wren;
        bit          chk_wd;
        logic [15:0] addr;
        logic [15:0] data;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, per_req, per_we;
    logic [15:0] cpu_addr, cpu_wdata, per_addr, per_wdata;
    logic        cpu_gnt, cpu_rvalid, per_gnt, per_rvalid;
    logic [15:0] cpu_rdata, per_rdata;
    logic        mem_en, mem_wren;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
`ifdef ARB_PERF_CNT_EN
    logic        perf_clr;
    logic [15:0] perf_cpu_grants, perf_per_grants, perf_conflicts;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t gq[$];
    exp_t rq[$];
    logic [15:0] ram [0:1023];

    mem_port_arbiter #(.WIDTH(16), .ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .per_req    (per_req),
        .per_we     (per_we),
        .per_addr   (per_addr),
        .per_wdata  (per_wdata),
        .per_gnt    (per_gnt),
        .per_rvalid (per_rvalid),
        .per_rdata  (per_rdata),
        .mem_en     (mem_en),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_clr        (perf_clr),
        .perf_cpu_grants (perf_cpu_grants),
        .perf_per_grants (perf_per_grants),
        .perf_conflicts  (perf_conflicts)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model, one-cycle read latency.
    always @(posedge clk) begin
        if (reset) begin
            ram[10'h010] <= 16'hBEEF;
            ram[10'h020] <= 16'h1234;
            ram[10'h021] <= 16'h5678;
        end else if (mem_en) begin
            if (mem_wren) ram[mem_addr[9:0]] <= mem_wdata;
            else          mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic exp_gnt(input bit per, input bit wren, input logic [15:0] addr,
                           input logic [15:0] wd, input int at);
        exp_t e;
        e.per = per; e.wren = wren; e.chk_wd = wren; e.addr = addr; e.data = wd; e.at = at;
        gq.push_back(e);
    endtask

    task automatic exp_rv(input bit per, input logic [15:0] data, input int at);
        exp_t e;
        e.per = per; e.wren = 1'b0; e.chk_wd = 1'b0; e.addr = 16'h0; e.data = data; e.at = at;
        rq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cpu_gnt || per_gnt) begin
            chk("gnt_exclusive", 32'(cpu_gnt & per_gnt), 32'd0);
            if (gq.size() == 0) begin
                chk("gnt_unexpected", 32'd1, 32'd0);
            end else begin
                e = gq.pop_front();
                chk("gnt_who",   32'(per_gnt), 32'(e.per));
                chk("gnt_cycle", 32'(cyc), 32'(e.at));
                chk("mem_en",    32'(mem_en), 32'd1);
                chk("mem_wren",  32'(mem_wren), 32'(e.wren));
                chk("mem_addr",  32'(mem_addr), 32'(e.addr));
                if (e.chk_wd) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
            end
        end
        if (cpu_rvalid || per_rvalid) begin
            chk("rvalid_exclusive", 32'(cpu_rvalid & per_rvalid), 32'd0);
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                chk("rvalid_who",   32'(per_rvalid), 32'(e.per));
                chk("rvalid_cycle", 32'(cyc), 32'(e.at));
                chk("rdata", 32'(per_rvalid ? per_rdata : cpu_rdata), 32'(e.data));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        per_req = 0; per_we = 0; per_addr = 0; per_wdata = 0;
`ifdef ARB_PERF_CNT_EN
        perf_clr = 0;
`endif
        tick();
        chk("rst_cpu_gnt",    32'(cpu_gnt), 32'd0);
        chk("rst_per_gnt",    32'(per_gnt), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_per_rvalid", 32'(per_rvalid), 32'd0);
        chk("rst_mem_en",     32'(mem_en), 32'd0);
        chk("rst_mem_wren",   32'(mem_wren), 32'd0);
        chk("rst_mem_addr",   32'(mem_addr), 32'd0);
        chk("rst_mem_wdata",  32'(mem_wdata), 32'd0);
        chk("rst_cpu_rdata",  32'(cpu_rdata), 32'd0);
        chk("rst_per_rdata",  32'(per_rdata), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single CPU read of 0x0010.
        n = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        exp_gnt(0, 0, 16'h0010, 16'h0, n + 1);
        exp_rv(0, 16'hBEEF, n + 2);
        tick(); tick();
        cpu_req = 0;
        tick(); tick();
        chk("cpu_rdata_hold", 32'(cpu_rdata), 32'hBEEF);
        chk("idle_mem_addr_hold", 32'(mem_addr), 32'h0010);
        chk("idle_mem_en", 32'(mem_en), 32'd0);

        // Peripheral back-to-back reads with req held high.
        n = cyc;
        per_req = 1; per_we = 0; per_addr = 16'h0020;
        exp_gnt(1, 0, 16'h0020, 16'h0, n + 1);
        exp_rv(1, 16'h1234, n + 2);
        exp_gnt(1, 0, 16'h0021, 16'h0, n + 3);
        exp_rv(1, 16'h5678, n + 4);
        tick(); tick();
        per_addr = 16'h0021;
        tick(); tick();
        per_req = 0;
        tick(); tick();

        // Continuous write collision: grants alternate starting with CPU.
        n = cyc;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h1111;
        per_req = 1; per_we = 1; per_addr = 16'h0031; per_wdata = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_gnt(0, 1, 16'h0030, 16'h1111, n + 1 + i);
            else            exp_gnt(1, 1, 16'h0031, 16'h2222, n + 1 + i);
        end
        repeat (6) tick();
        cpu_req = 0; per_req = 0;
        tick(); tick(); tick();

        // CPU write then read of the same address.
        n = cyc;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 16'hA5A5;
        exp_gnt(0, 1, 16'h0100, 16'hA5A5, n + 1);
        exp_gnt(0, 0, 16'h0100, 16'h0, n + 3);
        exp_rv(0, 16'hA5A5, n + 4);
        tick(); tick();
        cpu_we = 0;
        tick(); tick();
        cpu_req = 0;
        tick(); tick();
        chk("cpu_rdata_hold2", 32'(cpu_rdata), 32'hA5A5);

        // Reset asserted during PER_RD.
        n = cyc;
        per_req = 1; per_we = 0; per_addr = 16'h0020;
        exp_gnt(1, 0, 16'h0020, 16'h0, n + 1);
        tick(); tick();
        per_req = 0;
        reset = 1'b1;
        #1;
        chk("midrd_per_rvalid", 32'(per_rvalid), 32'd0);
        chk("midrd_per_rdata",  32'(per_rdata), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        n = cyc;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h4444;
        per_req = 1; per_we = 1; per_addr = 16'h0041; per_wdata = 16'h5555;
        exp_gnt(0, 1, 16'h0040, 16'h4444, n + 1);
        tick();
        cpu_req = 0; per_req = 0;
        tick(); tick();

`ifdef ARB_PERF_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n = cyc;
            cpu_req = 1; per_req = 1;
            if (i % 2 == 0) exp_gnt(0, 1, 16'h0040, 16'h4444, n + 1);
            else            exp_gnt(1, 1, 16'h0041, 16'h5555, n + 1);
            tick();
            cpu_req = 0; per_req = 0;
            tick(); tick();
        end
        for (int i = 0; i < 2; i++) begin
            n = cyc;
            cpu_req = 1;
            exp_gnt(0, 1, 16'h0040, 16'h4444, n + 1);
            tick();
            cpu_req = 0;
            tick();
        end
        tick();
        chk("perf_conflicts",  32'(perf_conflicts), 32'd4);
        chk("perf_cpu_grants", 32'(perf_cpu_grants), 32'd4);
        chk("perf_per_grants", 32'(perf_per_grants), 32'd2);
        perf_clr = 1;
        tick();
        perf_clr = 0;
        chk("perf_clr_conflicts",  32'(perf_conflicts), 32'd0);
        chk("perf_clr_cpu_grants", 32'(perf_cpu_grants), 32'd0);
        chk("perf_clr_per_grants", 32'(perf_per_grants), 32'd0);
`endif

        tick(); tick();
        chk("gnt_queue_drained",    32'(gq.size()), 32'd0);
        chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
